tdm_demultiplexer: RTL and testbench



---
 rtl/tdm_demultiplexer.sv | 125 ++++++++++++
 tb/tb_tdm_demultiplexer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demultiplexer.sv
// Receive side of a 4-slot TDM link: aligns on the slot-0 sync marker, stages
// slots 0..2, and publishes a complete four-word frame with a one-cycle strobe.
module tdm_demultiplexer #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sync,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic             frame_valid,
    output logic             addr0,
    output logic             addr1,
    output logic             locked,
    output logic             sync_err
);

    typedef enum logic {
        HUNT,
        LOCKED
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [1:0]       slot;
    logic [1:0]       slot_next;
    logic             store_en;
    logic [1:0]       store_slot;
    logic             complete;
    logic             misalign;
    logic [WIDTH-1:0] stage0;
    logic [WIDTH-1:0] stage1;
    logic [WIDTH-1:0] stage2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= HUNT;
            slot  <= 2'd0;
        end else begin
            state <= state_next;
            slot  <= slot_next;
        end
    end

    always_comb begin
        state_next = state;
        slot_next  = slot;
        store_en   = 1'b0;
        store_slot = 2'd0;
        complete   = 1'b0;
        misalign   = 1'b0;
        if (in_valid) begin
            unique case (state)
                HUNT: begin
                    if (in_sync) begin
                        state_next = LOCKED;
                        slot_next  = 2'd1;
                        store_en   = 1'b1;
                        store_slot = 2'd0;
                    end
                end
                LOCKED: begin
                    // A sync anywhere but slot 0 drops the partial frame and realigns.
                    if (in_sync && slot != 2'd0) begin
                        misalign   = 1'b1;
                        slot_next  = 2'd1;
                        store_en   = 1'b1;
                        store_slot = 2'd0;
                    end else if (slot == 2'd3) begin
                        complete  = 1'b1;
                        slot_next = 2'd0;
                    end else begin
                        store_en   = 1'b1;
                        store_slot = slot;
                        slot_next  = slot + 2'd1;
                    end
                end
                default: state_next = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage0 <= '0;
            stage1 <= '0;
            stage2 <= '0;
        end else if (store_en) begin
            unique case (store_slot)
                2'd0:    stage0 <= in_data;
                2'd1:    stage1 <= in_data;
                default: stage2 <= in_data;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out0        <= '0;
            out1        <= '0;
            out2        <= '0;
            out3        <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            frame_valid <= complete;
            sync_err    <= misalign;
            if (complete) begin
                out0 <= stage0;
                out1 <= stage1;
                out2 <= stage2;
                out3 <= in_data;
            end
        end
    end

    assign addr0  = slot[0];
    assign addr1  = slot[1];
    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_tdm_demultiplexer.sv
// Bench for tdm_demultiplexer: directed vector table, asynchronous reset checks,
// and random traffic against a queue-based frame model.
module tb_tdm_demultiplexer;

    localparam int W  = 4;
    localparam int VW = 4 * W + 5;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_sync;
    logic [W-1:0] out0, out1, out2, out3;
    logic         frame_valid, addr0, addr1, locked, sync_err;

    int checks   = 0;
    int failures = 0;

    tdm_demultiplexer #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_sync(in_sync), .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .frame_valid(frame_valid), .addr0(addr0), .addr1(addr1),
        .locked(locked), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit v, s;
        int d;
        bit fv;
        int o0, o1, o2, o3;
        int addr;
        bit lk, err;
    } vec_t;

    vec_t vecs[$];

    // Frame model: words of the current frame are collected in a queue.
    bit m_locked;
    int m_q[$];
    int m_out[4];
    bit m_fv, m_err;

    function automatic logic [VW-1:0] pack(bit fv, int o0, int o1, int o2, int o3,
                                           int addr, bit lk, bit err);
        logic [W-1:0] a0, a1, a2, a3;
        logic [1:0]   ad;
        a0 = o0[W-1:0]; a1 = o1[W-1:0]; a2 = o2[W-1:0]; a3 = o3[W-1:0];
        ad = addr[1:0];
        return {fv, a3, a2, a1, a0, ad, lk, err};
    endfunction

    function automatic logic [VW-1:0] observed();
        return {frame_valid, out3, out2, out1, out0, addr1, addr0, locked, sync_err};
    endfunction

    task automatic check(string name, logic [VW-1:0] got, logic [VW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got fv/o3/o2/o1/o0/addr/lk/err=%h required=%h", name, got, exp);
        end
    endtask

    task automatic add(bit v, bit s, int d, bit fv, int o0, int o1, int o2, int o3,
                       int addr, bit lk, bit err);
        vec_t r;
        r.v = v; r.s = s; r.d = d; r.fv = fv;
        r.o0 = o0; r.o1 = o1; r.o2 = o2; r.o3 = o3;
        r.addr = addr; r.lk = lk; r.err = err;
        vecs.push_back(r);
    endtask

    task automatic step(bit v, bit s, int d);
        @(negedge clk);
        in_valid = v;
        in_sync  = s;
        in_data  = d[W-1:0];
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_locked = 0;
        m_q.delete();
        for (int i = 0; i < 4; i++) m_out[i] = 0;
        m_fv = 0;
        m_err = 0;
    endtask

    task automatic model_step(bit v, bit s, int d);
        m_fv = 0;
        m_err = 0;
        if (v) begin
            if (!m_locked) begin
                if (s) begin
                    m_locked = 1;
                    m_q = '{d};
                end
            end else if (s && m_q.size() != 0) begin
                m_err = 1;
                m_q = '{d};
            end else begin
                m_q.push_back(d);
                if (m_q.size() == 4) begin
                    for (int i = 0; i < 4; i++) m_out[i] = m_q[i];
                    m_fv = 1;
                    m_q.delete();
                end
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", observed(), '0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_sync  = 1'b0;
        in_data  = '0;
        model_reset();
        #1;
        check("reset_state", observed(), '0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // hunt then first aligned frame 0,1,0,1
        add(1,0,1, 0, 0,0,0,0, 0,0,0);
        add(1,0,0, 0, 0,0,0,0, 0,0,0);
        add(1,1,0, 0, 0,0,0,0, 1,1,0);
        add(1,0,1, 0, 0,0,0,0, 2,1,0);
        add(1,0,0, 0, 0,0,0,0, 3,1,0);
        add(1,0,1, 1, 0,1,0,1, 0,1,0);
        // frame 1,1,0,0 with a gap after slot 1 (sync ignored while invalid)
        add(1,1,1, 0, 0,1,0,1, 1,1,0);
        add(1,0,1, 0, 0,1,0,1, 2,1,0);
        add(0,1,0, 0, 0,1,0,1, 2,1,0);
        add(1,0,0, 0, 0,1,0,1, 3,1,0);
        add(1,0,0, 1, 1,1,0,0, 0,1,0);
        // frame 0,1,1,0 without sync on slot 0
        add(1,0,0, 0, 1,1,0,0, 1,1,0);
        add(1,0,1, 0, 1,1,0,0, 2,1,0);
        add(0,0,0, 0, 1,1,0,0, 2,1,0);
        add(1,0,1, 0, 1,1,0,0, 3,1,0);
        add(1,0,0, 1, 0,1,1,0, 0,1,0);
        // sync at slot 2 -> realign, then complete 1,0,1,0
        add(1,0,1, 0, 0,1,1,0, 1,1,0);
        add(1,0,1, 0, 0,1,1,0, 2,1,0);
        add(1,1,1, 0, 0,1,1,0, 1,1,1);
        add(1,0,0, 0, 0,1,1,0, 2,1,0);
        add(1,0,1, 0, 0,1,1,0, 3,1,0);
        add(1,0,0, 1, 1,0,1,0, 0,1,0);
        // sync at slot 3 -> no completion, realign, complete 0,1,1,1
        add(1,0,1, 0, 1,0,1,0, 1,1,0);
        add(1,0,1, 0, 1,0,1,0, 2,1,0);
        add(1,0,1, 0, 1,0,1,0, 3,1,0);
        add(1,1,0, 0, 1,0,1,0, 1,1,1);
        add(1,0,1, 0, 1,0,1,0, 2,1,0);
        add(1,0,1, 0, 1,0,1,0, 3,1,0);
        add(1,0,1, 1, 0,1,1,1, 0,1,0);
        add(0,0,0, 0, 0,1,1,1, 0,1,0);

        foreach (vecs[i]) begin
            step(vecs[i].v, vecs[i].s, vecs[i].d);
            check($sformatf("vec%0d", i), observed(),
                  pack(vecs[i].fv, vecs[i].o0, vecs[i].o1, vecs[i].o2, vecs[i].o3,
                       vecs[i].addr, vecs[i].lk, vecs[i].err));
        end

        // mid-frame reset: two words staged, then cleared asynchronously
        step(1, 1, 5);
        step(1, 0, 6);
        apply_reset();

        for (int i = 0; i < 600; i++) begin
            bit v, s;
            int d;
            v = ($urandom_range(0, 9) < 7);
            s = ($urandom_range(0, 99) < 12);
            d = int'($urandom_range(0, (1 << W) - 1));
            step(v, s, d);
            model_step(v, s, d);
            check($sformatf("rand%0d", i), observed(),
                  pack(m_fv, m_out[0], m_out[1], m_out[2], m_out[3],
                       m_q.size(), m_locked, m_err));
            if (i == 300) apply_reset();
        end

        apply_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
